// File: rtl/para_seq.sv
// Measurement-window sequencer: gates sample-mover data into fixed-length windows
// separated by idle gaps, counts hit-detector events per window and reports one record per window.
module para_seq #(
    parameter int unsigned FLUSH_CYC = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic        cmd_abort,
    input  logic [15:0] cfg_win,
    input  logic [15:0] cfg_gap,
    input  logic [7:0]  cfg_nwin,
    input  logic [15:0] sm_data,
    input  logic        sm_vld,
    output logic [15:0] gt_data,
    output logic        gt_vld,
    input  logic [15:0] ph_ring,
    input  logic        ph_vld,
    output logic [15:0] res_hits,
    output logic [15:0] res_ring,
    output logic [7:0]  res_idx,
    output logic        res_vld,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_REPORT, S_GAP} state_t;

    typedef struct packed {
        logic [15:0] win;
        logic [15:0] gap;
        logic [7:0]  nwin;
    } cfg_t;

    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYC - 1);

    state_t      state_q, state_d;
    cfg_t        cfg_q;
    logic [15:0] sample_cnt, gap_cnt, hit_cnt, ring_reg;
    logic [7:0]  flush_cnt, win_idx;
    logic [15:0] res_hits_q, res_ring_q;
    logic [7:0]  res_idx_q;

    logic start_ok, last_smp, flush_end, gap_end, last_win, report, accept, hit_en;

    assign start_ok  = cmd_start && !cmd_abort && (cfg_win != 16'd0);
    assign last_smp  = sm_vld && (sample_cnt == cfg_q.win - 16'd1);
    assign flush_end = (flush_cnt == FLUSH_LAST);
    assign gap_end   = (gap_cnt == cfg_q.gap - 16'd1);
    assign last_win  = (cfg_q.nwin != 8'd0) && (win_idx == cfg_q.nwin - 8'd1);
    // abort suppresses the report that would otherwise be emitted this cycle
    assign report    = (state_q == S_REPORT) && !cmd_abort;
    assign accept    = (state_q == S_RUN) && sm_vld && !cmd_abort;
    assign hit_en    = (state_q == S_RUN) || (state_q == S_FLUSH);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_RUN;
            S_RUN:    if (last_smp) state_d = S_FLUSH;
            S_FLUSH:  if (flush_end) state_d = S_REPORT;
            S_REPORT: begin
                if (last_win)                 state_d = S_IDLE;
                else if (cfg_q.gap != 16'd0)  state_d = S_GAP;
                else                          state_d = S_RUN;
            end
            S_GAP:    if (gap_end) state_d = S_RUN;
            default:  state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && cmd_abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk_sys) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            cfg_q      <= '0;
            sample_cnt <= '0;
            gap_cnt    <= '0;
            flush_cnt  <= '0;
            hit_cnt    <= '0;
            ring_reg   <= '0;
            win_idx    <= '0;
            gt_vld     <= 1'b0;
            gt_data    <= '0;
            res_hits_q <= '0;
            res_ring_q <= '0;
            res_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            gt_vld  <= accept;
            if (accept) gt_data <= sm_data;
            case (state_q)
                S_IDLE: if (start_ok) begin
                    cfg_q      <= '{win: cfg_win, gap: cfg_gap, nwin: cfg_nwin};
                    sample_cnt <= '0;
                    hit_cnt    <= '0;
                    ring_reg   <= '0;
                    win_idx    <= '0;
                end
                S_RUN: begin
                    flush_cnt <= '0;
                    if (sm_vld) sample_cnt <= sample_cnt + 16'd1;
                end
                S_FLUSH: flush_cnt <= flush_cnt + 8'd1;
                S_REPORT: if (report) begin
                    res_hits_q <= hit_cnt;
                    res_ring_q <= ring_reg;
                    res_idx_q  <= win_idx;
                    if (!last_win) begin
                        win_idx    <= win_idx + 8'd1;
                        sample_cnt <= '0;
                        hit_cnt    <= '0;
                        ring_reg   <= '0;
                        gap_cnt    <= '0;
                    end
                end
                S_GAP: gap_cnt <= gap_cnt + 16'd1;
                default: ;
            endcase
            if (hit_en && ph_vld) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                ring_reg <= ph_ring;
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign res_vld  = report;
    assign done     = report && last_win;
    assign res_hits = report ? hit_cnt  : res_hits_q;
    assign res_ring = report ? ring_reg : res_ring_q;
    assign res_idx  = report ? win_idx  : res_idx_q;
endmodule

// File: tb/tb_para_seq.sv
// Directed bench for para_seq: expected gated samples and result records are queued with
// their due cycle when stimulus is driven, then popped and compared as the DUT emits them.
module tb_para_seq;
    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_start = 1'b0, cmd_abort = 1'b0;
    logic [15:0] cfg_win = '0, cfg_gap = '0;
    logic [7:0]  cfg_nwin = '0;
    logic [15:0] sm_data = '0, ph_ring = '0;
    logic        sm_vld = 1'b0, ph_vld = 1'b0;
    logic [15:0] gt_data, res_hits, res_ring;
    logic [7:0]  res_idx;
    logic        gt_vld, res_vld, busy, done;

    para_seq #(.FLUSH_CYC(4)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_win(cfg_win), .cfg_gap(cfg_gap), .cfg_nwin(cfg_nwin),
        .sm_data(sm_data), .sm_vld(sm_vld), .gt_data(gt_data), .gt_vld(gt_vld),
        .ph_ring(ph_ring), .ph_vld(ph_vld), .res_hits(res_hits), .res_ring(res_ring),
        .res_idx(res_idx), .res_vld(res_vld), .busy(busy), .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    int gt_cnt = 0, res_cnt = 0, done_cnt = 0;

    typedef struct {
        logic [15:0] d;
        int          c;
    } gt_exp_t;
    typedef struct {
        logic [15:0] hits;
        logic [15:0] ring;
        logic [7:0]  idx;
        logic        dn;
        int          c;
    } res_exp_t;

    gt_exp_t  gt_q[$];
    res_exp_t res_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        gt_exp_t  ge;
        res_exp_t re;
        if (gt_vld) begin
            gt_cnt++;
            check("gt_expected", 32'(gt_q.size() != 0), 32'd1);
            if (gt_q.size() != 0) begin
                ge = gt_q.pop_front();
                check("gt_data", 32'(gt_data), 32'(ge.d));
                check("gt_cycle", 32'(cyc), 32'(ge.c));
            end
        end
        if (res_vld) begin
            res_cnt++;
            check("res_expected", 32'(res_q.size() != 0), 32'd1);
            if (res_q.size() != 0) begin
                re = res_q.pop_front();
                check("res_hits", 32'(res_hits), 32'(re.hits));
                check("res_ring", 32'(res_ring), 32'(re.ring));
                check("res_idx", 32'(res_idx), 32'(re.idx));
                check("res_done", 32'(done), 32'(re.dn));
                check("res_cycle", 32'(cyc), 32'(re.c));
            end
        end
        if (done) begin
            done_cnt++;
            check("done_with_res", 32'(res_vld), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_in();
        sm_vld = 1'b0; ph_vld = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] w, input logic [15:0] g, input logic [7:0] n);
        cfg_win = w; cfg_gap = g; cfg_nwin = n; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic push_gt(input logic [15:0] d);
        gt_q.push_back('{d: d, c: cyc + 1});
    endtask

    task automatic push_res(input logic [15:0] h, input logic [15:0] r, input logic [7:0] i,
                            input logic dn, input int c);
        res_q.push_back('{hits: h, ring: r, idx: i, dn: dn, c: c});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_gt_vld"}, 32'(gt_vld), 32'd0);
        check({tag, "_gt_data"}, 32'(gt_data), 32'd0);
        check({tag, "_res_vld"}, 32'(res_vld), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_res_hits"}, 32'(res_hits), 32'd0);
        check({tag, "_res_ring"}, 32'(res_ring), 32'd0);
        check({tag, "_res_idx"}, 32'(res_idx), 32'd0);
    endtask

    initial begin
        int t, g0, r0, d0;
        // reset
        idle_in();
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk_sys);
        check_all_zero("reset");

        // basic window: 8 samples, hits with rings 5,9,2
        tick();
        g0 = gt_cnt;
        start_run(16'd8, 16'd0, 8'd1);
        @(negedge clk_sys);
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            sm_vld = 1'b1;
            sm_data = 16'(16'h100 + i);
            push_gt(sm_data);
            ph_vld = (i == 1 || i == 3 || i == 6);
            ph_ring = (i == 1) ? 16'd5 : (i == 3) ? 16'd9 : 16'd2;
            if (i < 7) tick();
        end
        t = cyc;
        push_res(16'd3, 16'd2, 8'd0, 1'b1, t + 5);
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle_in();
            @(negedge clk_sys);
            if (k == 4) check("basic_res_not_early", 32'(res_vld), 32'd0);
        end
        check("basic_res_vld", 32'(res_vld), 32'd1);
        check("basic_done", 32'(done), 32'd1);
        tick();
        @(negedge clk_sys);
        check("basic_busy_low", 32'(busy), 32'd0);
        check("basic_gt_count", 32'(gt_cnt - g0), 32'd8);

        // multi-window with gap; hits in REPORT/GAP must be ignored
        tick();
        g0 = gt_cnt; r0 = res_cnt; d0 = done_cnt;
        start_run(16'd4, 16'd10, 8'd3);
        for (int k = 0; k <= 46; k++) begin
            sm_vld = 1'b1;
            sm_data = 16'(16'h200 + k);
            if ((k % 19) < 4) push_gt(sm_data);
            ph_vld = ((k % 19) >= 8);
            ph_ring = 16'hEE;
            if ((k % 19) == 3) push_res(16'd0, 16'd0, 8'(k / 19), (k / 19) == 2, cyc + 5);
            tick();
        end
        idle_in();
        @(negedge clk_sys);
        check("multi_busy_low", 32'(busy), 32'd0);
        check("multi_gt_count", 32'(gt_cnt - g0), 32'd12);
        check("multi_res_count", 32'(res_cnt - r0), 32'd3);
        check("multi_done_count", 32'(done_cnt - d0), 32'd1);

        // flush boundary: hit at last+4 counted, last+5 not
        tick();
        start_run(16'd2, 16'd0, 8'd1);
        sm_vld = 1'b1; sm_data = 16'h0301; push_gt(sm_data);
        tick();
        sm_data = 16'h0302; push_gt(sm_data);
        t = cyc;
        push_res(16'd1, 16'd7, 8'd0, 1'b1, t + 5);
        for (int j = 1; j <= 6; j++) begin
            tick();
            idle_in();
            if (j == 4) begin ph_vld = 1'b1; ph_ring = 16'd7; end
            if (j == 5) begin ph_vld = 1'b1; ph_ring = 16'd8; end
        end

        // illegal / ignored starts
        start_run(16'd0, 16'd0, 8'd1);
        @(negedge clk_sys);
        check("win0_start_ignored", 32'(busy), 32'd0);
        tick();
        cfg_win = 16'd5; cmd_start = 1'b1; cmd_abort = 1'b1;
        tick();
        idle_in();
        @(negedge clk_sys);
        check("start_abort_idle", 32'(busy), 32'd0);
        tick();
        start_run(16'd3, 16'd0, 8'd1);
        cfg_win = 16'd50; cmd_start = 1'b1;
        sm_vld = 1'b1; sm_data = 16'h0401; push_gt(sm_data);
        tick();
        cmd_start = 1'b0;
        sm_data = 16'h0402; push_gt(sm_data);
        tick();
        sm_data = 16'h0403; push_gt(sm_data);
        push_res(16'd0, 16'd0, 8'd0, 1'b1, cyc + 5);
        repeat (7) begin tick(); idle_in(); end

        // abort mid-run
        g0 = gt_cnt; r0 = res_cnt; d0 = done_cnt;
        start_run(16'd100, 16'd0, 8'd0);
        for (int i = 0; i < 50; i++) begin
            sm_vld = 1'b1; sm_data = 16'(16'h500 + i); push_gt(sm_data);
            tick();
        end
        sm_data = 16'h05FF; cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        @(negedge clk_sys);
        check("abort_gt_off", 32'(gt_vld), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        repeat (8) tick();
        idle_in();
        @(negedge clk_sys);
        check("abort_gt_count", 32'(gt_cnt - g0), 32'd50);
        check("abort_no_res", 32'(res_cnt - r0), 32'd0);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        tick();
        start_run(16'd3, 16'd0, 8'd1);
        for (int i = 0; i < 3; i++) begin
            sm_vld = 1'b1; sm_data = 16'(16'h600 + i); push_gt(sm_data);
            ph_vld = (i == 1); ph_ring = 16'h55;
            if (i < 2) tick();
        end
        push_res(16'd1, 16'h55, 8'd0, 1'b1, cyc + 5);
        repeat (7) begin tick(); idle_in(); end

        // synchronous reset in FLUSH
        r0 = res_cnt;
        start_run(16'd1, 16'd0, 8'd1);
        sm_vld = 1'b1; sm_data = 16'h0701; push_gt(sm_data);
        ph_vld = 1'b1; ph_ring = 16'h77;
        tick();
        idle_in();
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        @(negedge clk_sys);
        check_all_zero("flush_reset");
        repeat (8) tick();
        check("flush_reset_no_res", 32'(res_cnt - r0), 32'd0);

        // hit counter saturation
        start_run(16'd1, 16'd0, 8'd1);
        ph_vld = 1'b1; ph_ring = 16'h1234;
        repeat (70000) tick();
        sm_vld = 1'b1; sm_data = 16'hCAFE; push_gt(sm_data);
        ph_ring = 16'hBEEF;
        push_res(16'hFFFF, 16'hBEEF, 8'd0, 1'b1, cyc + 5);
        for (int j = 1; j <= 6; j++) begin
            tick();
            sm_vld = 1'b0;
            if (j == 5) ph_vld = 1'b0;
        end
        idle_in();
        repeat (3) tick();

        check("gt_queue_drained", 32'(gt_q.size()), 32'd0);
        check("res_queue_drained", 32'(res_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/para_seq.md
# para_seq

Measurement-window sequencer for the parameter-extraction path. It sits between the sample-mover output (sm_data/sm_vld) and the para datapath. It gates samples into fixed-length windows separated by programmable gaps, and counts hit events (ph_vld/ph_ring) returned by the hit detector during each window. It emits one result record per window, plus a done pulse at the end of a finite run.

## Interface
Parameters:
- FLUSH_CYC, default 4: cycles after a window's last sample during which ph_vld is still counted, covering the hit-detector latency. Legal range is 1..255.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-high; it keeps the codebase port name.
- cmd_start  in  1  single-cycle pulse that starts a run.
- cmd_abort  in  1  single-cycle pulse that terminates a run.
- cfg_win  in  16  samples per window. 0 is illegal, and start is then ignored.
- cfg_gap  in  16  idle clock cycles between windows.
- cfg_nwin  in  8  windows per run. 0 means continuous until abort.
- sm_data  in  16  sample data from the sample mover.
- sm_vld  in  1  sample valid.
- gt_data  out  16  gated sample to the para datapath.
- gt_vld  out  1  gated sample valid.
- ph_ring  in  16  ring value from the hit detector.
- ph_vld  in  1  hit event valid.
- res_hits  out  16  hit count of the completed window.
- res_ring  out  16  last ph_ring captured in the window.
- res_idx  out  8  window index, starting at 0.
- res_vld  out  1  single-cycle result strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse at the end of a finite run.

## Operation
- States:
  - IDLE: waits for a start.
  - RUN: collects samples into the current window.
  - FLUSH: counts late hits after the last sample.
  - REPORT: 1 cycle, emits the result.
  - GAP: idle cycles between windows.
- Config latch: cfg_win, cfg_gap and cfg_nwin are latched on an accepted start. Later changes have no effect until the next start.
- IDLE → RUN: on cmd_start=1 with cmd_abort=0 and cfg_win≠0. Entering RUN clears sample_cnt, hit_cnt, ring_reg and win_idx.
- cmd_start while busy is ignored.
- RUN:
  - Each sm_vld=1 is forwarded and increments sample_cnt.
  - The sample taken when sample_cnt==win−1 is forwarded, and the FSM moves to FLUSH.
  - Samples outside RUN are dropped, so gt_vld stays 0.
- FLUSH: lasts exactly FLUSH_CYC cycles, then goes to REPORT.
- Hit counting: applies in RUN and FLUSH.
  - Each ph_vld=1 increments hit_cnt, saturating at 0xFFFF.
  - It also loads ring_reg with ph_ring.
  - ph_vld in IDLE, GAP or REPORT is ignored.
- REPORT:
  - res_hits=hit_cnt, res_ring=ring_reg, res_idx=win_idx, res_vld=1.
  - If nwin≠0 and win_idx==nwin−1: go to IDLE and pulse done in the same cycle as res_vld.
  - Otherwise win_idx increments (wrapping at 255 in continuous mode), counters clear, and the FSM goes to GAP if gap≠0, else to RUN.
- GAP: lasts exactly `gap` cycles, then goes to RUN.
- Abort: cmd_abort in any busy state forces IDLE on the next edge.
  - No res_vld or done is emitted.
  - gt_vld is 0 from the next cycle.
  - Abort wins over a simultaneous start and over a REPORT in the same cycle.
- res_* fields hold their values between strobes. Only res_vld and done are pulses.

## Timing
- Reset: every output is 0 and the state is IDLE. Reset has priority over all inputs. A reset mid-run discards the window.
- Start: cmd_start at cycle t gives busy=1 at t+1. The first sample can be accepted at t+1.
- Sample path: sm_vld/sm_data accepted in RUN at cycle t appears on gt_vld/gt_data at t+1. The path is registered, with no combinational passthrough.
- Last sample accepted at cycle t:
  - FLUSH covers t+1..t+FLUSH_CYC.
  - REPORT is at t+FLUSH_CYC+1, with res_vld/done asserted in that cycle.
- Hit counting includes ph_vld at cycle t+FLUSH_CYC and excludes t+FLUSH_CYC+1.
- Window turnaround:
  - With gap=0, RUN is re-entered at t+FLUSH_CYC+2.
  - Otherwise GAP covers t+FLUSH_CYC+2..t+FLUSH_CYC+1+gap.
- End of run: busy falls in the cycle after REPORT.
- Counter widths: sample_cnt 16 bit, gap counter 16 bit, flush counter 8 bit. There is no overflow because all counters are bounded by the latched config.

## Test plan
- Basic window: win=8, gap=0, nwin=1, FLUSH_CYC=4, 8 contiguous samples, ph_vld on 3 cycles with rings 5,9,2 → 8 gt_vld pulses each one cycle late; res_vld at 5 cycles after the last sample with res_hits=3, res_ring=2, res_idx=0; done in the same cycle; busy low the following cycle.
- Multi-window with gap: win=4, gap=10, nwin=3, continuous sm_vld → 3 res_vld with idx 0,1,2; exactly 12 gt_vld total; no gt_vld during the 10 GAP cycles; done only on idx 2.
- Flush boundary: ph_vld at last-sample+4 and at +5 → only the first is counted (res_hits=1).
- Abort mid-run: win=100, abort after 50 samples → gt_vld 0 from the next cycle, no res_vld, no done; a new start afterwards yields res_idx=0.
- Illegal/ignored starts:
  - cfg_win=0 with start → busy stays 0.
  - Start while busy → ignored.
  - Simultaneous start+abort in IDLE → stays IDLE.
- Reset and saturation:
  - Synchronous reset asserted mid-FLUSH → all outputs 0 next cycle.
  - 70000 ph_vld in one window → res_hits=0xFFFF.
